// File: rtl/seq_detect_param.sv
// Parametrised Moore serial sequence detector.
// The pattern (1..MAX_LEN bits) and the overlap mode can be changed at run time.
// Incoming bits count only when in_valid is high.
// A one-cycle registered match pulse is driven on out.
// A saturating counter keeps a running total of matches.
module seq_detect_param #(
   parameter int                 MAX_LEN = 8,
   parameter int                 CNT_W   = 16,
   parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'('h15),
   parameter int                 RST_LEN = 5,
   parameter logic               RST_OVL = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in,
   input  logic                             in_valid,
   input  logic                             cfg_load,
   input  logic [MAX_LEN-1:0]               cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
   input  logic                             cfg_ovl,
   output logic                             out,
   output logic [CNT_W-1:0]                 match_cnt
);

   localparam int            LW    = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

   // Active configuration
   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic               ovl;

   // History of accepted bits (newest in bit 0) and how many of them are valid
   logic [MAX_LEN-1:0] hist;
   logic [LW-1:0]      fill;

   logic [MAX_LEN-1:0] hist_next;
   logic [LW-1:0]      fill_next;
   logic [MAX_LEN-1:0] mask;
   logic [LW-1:0]      len_clamped;
   logic               hit;

   // Compute the history after the candidate bit, the compare mask and the hit flag
   always_comb begin
      hist_next = {hist[MAX_LEN-2:0], in};
      fill_next = (fill == MAX_L) ? fill : fill + LW'(1);
      mask      = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
      // len == 0 disables the detector.
      // Pattern bits at or above len are masked off.
      hit         = (len != '0) && (fill_next >= len) &&
                    (((hist_next ^ pat) & mask) == '0);
      len_clamped = (cfg_len > MAX_L) ? MAX_L : cfg_len;
   end

   // Detector state, configuration, registered match pulse and saturating counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pat       <= RST_PAT;
         len       <= LW'(RST_LEN);
         ovl       <= RST_OVL;
         hist      <= '0;
         fill      <= '0;
         out       <= 1'b0;
         match_cnt <= '0;
      end else if (cfg_load) begin
         // A config load takes priority over a bit arriving in the same cycle.
         // That bit is dropped.
         pat  <= cfg_pattern;
         len  <= len_clamped;
         ovl  <= cfg_ovl;
         hist <= '0;
         fill <= '0;
         out  <= 1'b0;
      end else if (in_valid) begin
         hist <= hist_next;
         out  <= hit;
         if (hit) begin
            // In non-overlapping mode, none of the completing bits may start the next match.
            fill <= ovl ? fill_next : '0;
            if (match_cnt != {CNT_W{1'b1}}) begin
               match_cnt <= match_cnt + CNT_W'(1);
            end
         end else begin
            fill <= fill_next;
         end
      end else begin
         out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param.
// Two instances share the same stimulus: one with a 16-bit counter and one with a 2-bit counter.
// A reference model built on a bit queue predicts each cycle's out and counts.
// The monitor compares those predictions against both instances.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in = 1'b0;
   logic       in_valid = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_ovl = 1'b0;
   logic        out_a, out_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   int total = 0;
   int bad   = 0;

   // expected entry: {out, cnt16, cnt2}
   logic [18:0] exp_q[$];

   // reference model state
   int unsigned seen[$];
   logic [7:0]  m_pat;
   int          m_len;
   logic        m_ovl;
   longint      m_count;

   seq_detect_param #(.MAX_LEN(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
      .out(out_a), .match_cnt(cnt_a));

   seq_detect_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
      .out(out_b), .match_cnt(cnt_b));

   // clock
   always #5 clk = ~clk;

   // does the tail of the accepted-bit stream spell the pattern (first bit = pat[len-1])?
   function automatic logic model_match();
      int n = seen.size();
      if (m_len == 0 || n < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         if (seen[n - m_len + k] != 32'(m_pat[m_len - 1 - k])) return 1'b0;
      end
      return 1'b1;
   endfunction

   // drive one cycle of inputs and push the expected response after the next edge
   task automatic step(input logic r, input logic v, input logic b, input logic l,
                       input logic [7:0] p, input logic [3:0] ln, input logic o);
      logic        e_out;
      logic [15:0] e16;
      logic [1:0]  e2;
      @(posedge clk);
      #2;
      rst = r; in_valid = v; in = b; cfg_load = l;
      cfg_pattern = p; cfg_len = ln; cfg_ovl = o;
      e_out = 1'b0;
      if (r) begin
         seen.delete(); m_pat = 8'h15; m_len = 5; m_ovl = 1'b1; m_count = 0;
      end else if (l) begin
         seen.delete(); m_pat = p; m_len = (ln > 8) ? 8 : int'(ln); m_ovl = o;
      end else if (v) begin
         seen.push_back(int'(b));
         e_out = model_match();
         if (e_out) begin
            m_count++;
            if (!m_ovl) seen.delete();
         end
         if (seen.size() > 8) void'(seen.pop_front());
      end
      e16 = (m_count > 65535) ? 16'hffff : 16'(m_count);
      e2  = (m_count > 3) ? 2'd3 : 2'(m_count);
      exp_q.push_back({e_out, e16, e2});
   endtask

   task automatic bit_in(input logic b);
      step(1'b0, 1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic do_rst();
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] ln, input logic o,
                       input logic v, input logic b);
      step(1'b0, v, b, 1'b1, p, ln, o);
   endtask

   task automatic stream(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
   endtask

   // monitor: one expected entry per cycle, compared shortly after the edge
   initial begin
      logic [18:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (out_a !== e[18]) begin
               bad++;
               $display("FAIL out: got %b expected %b at %0t", out_a, e[18], $time);
            end
            total++;
            if (cnt_a !== e[17:2]) begin
               bad++;
               $display("FAIL cnt16: got %0d expected %0d at %0t", cnt_a, e[17:2], $time);
            end
            total++;
            if (out_b !== e[18] || cnt_b !== e[1:0]) begin
               bad++;
               $display("FAIL cnt2: got out=%b cnt=%0d expected out=%b cnt=%0d at %0t",
                        out_b, cnt_b, e[18], e[1:0], $time);
            end
         end
      end
   end

   // stimulus
   initial begin
      int wait_cycles;
      // 1: default configuration, overlapping 1010101 -> two hits
      do_rst();
      stream(16'b1010101, 7);
      idle();
      // 2: non-overlapping mode
      load(8'h15, 4'd5, 1'b0, 1'b0, 1'b0);
      stream(16'b1010110101, 10);
      load(8'h15, 4'd5, 1'b0, 1'b0, 1'b0);
      stream(16'b1010101, 7);
      // 3: default config with gaps of invalid cycles
      do_rst();
      for (int i = 0; i < 5; i++) begin
         bit_in(1'(~i[0]));
         repeat (3) idle();
      end
      // 4: load a new pattern mid-stream while a bit is also offered
      stream(16'b101, 3);
      load(8'h06, 4'd3, 1'b1, 1'b1, 1'b0);
      stream(16'b110, 3);
      idle();
      // 6: reset mid-stream, then reset restores the default pattern
      stream(16'b1010, 4);
      do_rst();
      bit_in(1'b1);
      stream(16'b10101, 5);
      load(8'h06, 4'd3, 1'b1, 1'b0, 1'b0);
      do_rst();
      stream(16'b10101, 5);
      // 5: counter saturation on the 2-bit instance
      do_rst();
      load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
      repeat (5) bit_in(1'b1);
      // boundaries: length 0, clamped length, full-length pattern, upper pattern bits ignored
      load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      repeat (6) bit_in(1'b1);
      load(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0);
      stream(16'b1010010110100101, 16);
      load(8'hF3, 4'd2, 1'b0, 1'b0, 1'b0);
      stream(16'b11111, 5);
      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_rst();
         end else if ($urandom_range(0, 39) == 0) begin
            load(8'($urandom()), 4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                 8'($urandom()), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         end
      end
      idle();
      // drain the scoreboard with a bounded wait
      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
